fan_speed_sequencer: RTL and testbench

Command-side driver for the fan speed controller. It accepts a requested target speed over a valid/ready handshake and emits single-cycle `update` pulses with `up`/`down` to step the controller toward that target. After each step it waits a programmable settling gap and then re-checks the controller's `speed` feedback. It also provides an emergency-stop path and an error flag when the feedback fails to converge.

---
 rtl/fan_speed_sequencer_if.sv | 23 ++
 rtl/fan_speed_sequencer.sv | 122 ++++++++++++
 tb/tb_fan_speed_sequencer.sv | 168 ++++++++++++++++
 3 files changed

// File: rtl/fan_speed_sequencer_if.sv
// Command/feedback bundle between a target requester, the sequencer and the fan controller.
interface fan_speed_sequencer_if;
    logic       req_valid;
    logic [1:0] req_target;
    logic       req_ready;
    logic       estop;
    logic [1:0] speed_fb;
    logic       update;
    logic       down;
    logic       up;
    logic       done;
    logic       err;

    modport master (
        output req_valid, req_target, estop, speed_fb,
        input  req_ready, update, down, up, done, err
    );

    modport slave (
        input  req_valid, req_target, estop, speed_fb,
        output req_ready, update, down, up, done, err
    );
endinterface

// File: rtl/fan_speed_sequencer.sv
// Steps the fan controller toward a requested speed one command at a time,
// re-checking feedback after a settling gap; includes emergency stop and non-convergence error.
module fan_speed_sequencer #(
    parameter int unsigned STEP_GAP = 4
) (
    input logic                   clk,
    input logic                   reset,
    fan_speed_sequencer_if.slave  bus
);
    localparam int unsigned GAP_W = $clog2(STEP_GAP + 1);

    typedef enum logic [3:0] {
        S_IDLE,
        S_CHECK,
        S_ISSUE_UP,
        S_ISSUE_DN,
        S_ISSUE_STOP,
        S_WAIT,
        S_EWAIT,
        S_DONE,
        S_ERR
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [1:0]         r_target;
    logic [1:0]         r_steps;
    logic [GAP_W-1:0]   r_gap;
    logic               r_abort;
    logic               r_req_ready;
    logic               r_update;
    logic               r_up;
    logic               r_down;
    logic               r_done;
    logic               r_err;
    logic               w_accept;
    logic               w_estop_take;
    logic               w_gap_last;

    // estop preempts every state except the stop it already caused and its settling gap
    assign w_estop_take = bus.estop && !(r_state == S_ISSUE_STOP && r_abort) && (r_state != S_EWAIT);
    assign w_accept     = (r_state == S_IDLE) && bus.req_valid && !bus.estop;
    assign w_gap_last   = (r_gap == GAP_W'(1));

    always_comb begin
        w_next = r_state;
        if (w_estop_take) begin
            w_next = S_ISSUE_STOP;
        end else begin
            case (r_state)
                S_IDLE:       if (w_accept) w_next = S_CHECK;
                S_CHECK: begin
                    if (bus.speed_fb == r_target)  w_next = S_DONE;
                    else if (r_steps == 2'd3)      w_next = S_ERR;
                    else if (r_target == 2'd0)     w_next = S_ISSUE_STOP;
                    else if (bus.speed_fb < r_target) w_next = S_ISSUE_UP;
                    else                           w_next = S_ISSUE_DN;
                end
                S_ISSUE_UP,
                S_ISSUE_DN:   w_next = S_WAIT;
                S_ISSUE_STOP: w_next = r_abort ? S_EWAIT : S_WAIT;
                S_WAIT:       if (w_gap_last) w_next = S_CHECK;
                S_EWAIT:      if (w_gap_last) w_next = bus.estop ? S_ISSUE_STOP : S_IDLE;
                S_DONE,
                S_ERR:        w_next = S_IDLE;
                default:      w_next = S_IDLE;
            endcase
        end
    end

    // State, datapath registers and outputs decoded from the state being entered
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_target    <= 2'd0;
            r_steps     <= 2'd0;
            r_gap       <= GAP_W'(0);
            r_abort     <= 1'b0;
            r_req_ready <= 1'b1;
            r_update    <= 1'b0;
            r_up        <= 1'b0;
            r_down      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next;

            if (w_accept) begin
                r_target <= bus.req_target;
                r_steps  <= 2'd0;
            end

            if (w_estop_take)
                r_abort <= 1'b1;
            else if (r_state == S_EWAIT && w_next == S_IDLE)
                r_abort <= 1'b0;

            case (r_state)
                S_ISSUE_UP, S_ISSUE_DN, S_ISSUE_STOP: begin
                    r_steps <= r_steps + 2'd1;
                    r_gap   <= GAP_W'(STEP_GAP);
                end
                S_WAIT, S_EWAIT: r_gap <= r_gap - GAP_W'(1);
                default: ;
            endcase

            r_req_ready <= (w_next == S_IDLE);
            r_update    <= (w_next inside {S_ISSUE_UP, S_ISSUE_DN, S_ISSUE_STOP});
            r_up        <= (w_next inside {S_ISSUE_UP, S_ISSUE_STOP});
            r_down      <= (w_next inside {S_ISSUE_DN, S_ISSUE_STOP});
            r_done      <= (w_next == S_DONE);
            r_err       <= (w_next == S_ERR);
        end
    end

    assign bus.req_ready = r_req_ready;
    assign bus.update    = r_update;
    assign bus.up        = r_up;
    assign bus.down      = r_down;
    assign bus.done      = r_done;
    assign bus.err       = r_err;
endmodule

// File: tb/tb_fan_speed_sequencer.sv
// Randomized bench: per-request expected output trace built from the stepping rules, compared cycle by cycle.
module tb_fan_speed_sequencer;
    localparam int G = 4;
    // observed vector layout: {req_ready, update, up, down, done, err}
    localparam logic [5:0] V_RDY  = 6'b100000;
    localparam logic [5:0] V_UP   = 6'b011000;
    localparam logic [5:0] V_DN   = 6'b010100;
    localparam logic [5:0] V_STOP = 6'b011100;
    localparam logic [5:0] V_DONE = 6'b000010;
    localparam logic [5:0] V_ERR  = 6'b000001;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] fan_spd;
    logic       fan_ld;
    logic [1:0] fan_ld_val;
    logic       fan_stuck;
    int         n_checks = 0;
    int         n_errors = 0;
    logic [5:0] exp_v [0:127];

    fan_speed_sequencer_if bus ();

    fan_speed_sequencer #(.STEP_GAP(G)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.speed_fb = fan_spd;

    // Fan controller stand-in: acts on update at the end of the strobe cycle
    always @(posedge clk) begin
        if (fan_ld)
            fan_spd <= fan_ld_val;
        else if (bus.update && !fan_stuck) begin
            if (bus.up && bus.down)                fan_spd <= 2'd0;
            else if (bus.up && fan_spd != 2'd3)    fan_spd <= fan_spd + 2'd1;
            else if (bus.down && fan_spd != 2'd0)  fan_spd <= fan_spd - 2'd1;
        end
    end

    function automatic logic [5:0] obs();
        return {bus.req_ready, bus.update, bus.up, bus.down, bus.done, bus.err};
    endfunction

    task automatic check(input string tag, input logic [5:0] got, input logic [5:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %b expected %b", tag, got, want);
        end
    endtask

    // Cycle j = j-th cycle after the accept edge; CHECK at 1, a step every G+2 cycles
    task automatic build_exp(input logic [1:0] sp0, input logic [1:0] t, input bit stuck,
                             input bit est_en, input int est_c, input int est_h, output int last);
        int pos;
        int steps;
        int sp;
        int ev;
        logic [5:0] v;
        for (int i = 0; i < 128; i++) exp_v[i] = 6'b0;
        pos = 1; steps = 0; sp = int'(sp0); last = -1;
        while (last < 0) begin
            ev = pos + 1;
            if (sp == int'(t))        v = V_DONE;
            else if (steps == 3)      v = V_ERR;
            else if (t == 2'd0)       v = V_STOP;
            else if (sp < int'(t))    v = V_UP;
            else                      v = V_DN;
            if (!est_en || ev <= est_c) exp_v[ev] = v;
            if (v == V_DONE || v == V_ERR) begin
                last = ev;
            end else begin
                if (!stuck) sp = (v == V_STOP) ? 0 : (v == V_UP) ? sp + 1 : sp - 1;
                steps++;
                pos += G + 2;
            end
        end
        if (est_en) begin
            pos = est_c + 1;
            last = -1;
            while (last < 0) begin
                exp_v[pos] = V_STOP;
                if (pos + G <= est_c + est_h - 1) pos += G + 1;
                else last = pos + G;
            end
        end
        exp_v[last + 1] = V_RDY;
    endtask

    // Entered and left at a negedge with the DUT idle
    task automatic run_trial(input int id, input logic [1:0] sp0, input logic [1:0] t, input bit stuck,
                             input bit est_en, input int est_c_in, input int est_h);
        int last;
        int est_c;
        est_c = est_c_in;
        if (est_en && est_c < 0) begin
            build_exp(sp0, t, stuck, 1'b0, 0, 0, last);
            est_c = int'($urandom_range(last, 0));
        end
        build_exp(sp0, t, stuck, est_en, est_c, est_h, last);
        fan_ld_val = sp0; fan_ld = 1'b1; fan_stuck = stuck;
        @(posedge clk); @(negedge clk);
        fan_ld = 1'b0;
        bus.req_valid  = 1'b1;
        bus.req_target = t;
        bus.estop      = est_en && (est_c == 0);
        for (int j = 1; j <= last + 1; j++) begin
            @(posedge clk); @(negedge clk);
            check($sformatf("trial%0d cyc%0d", id, j), obs(), exp_v[j]);
            if (j <= last) begin
                bus.req_valid  = 1'($urandom_range(1, 0));
                bus.req_target = 2'($urandom);
            end else begin
                bus.req_valid  = 1'b0;
            end
            bus.estop = est_en && (j >= est_c) && (j <= est_c + est_h - 1);
        end
        bus.estop = 1'b0;
        bus.req_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        bus.req_valid = 1'b0; bus.req_target = 2'd0; bus.estop = 1'b0;
        fan_ld = 1'b1; fan_ld_val = 2'd0; fan_stuck = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset", obs(), V_RDY);
        reset = 1'b0; fan_ld = 1'b0;

        run_trial(0, 2'd0, 2'd3, 1'b0, 1'b0, 0, 0);   // 0->3 ramp
        run_trial(1, 2'd3, 2'd1, 1'b0, 1'b0, 0, 0);   // two downs
        run_trial(2, 2'd2, 2'd0, 1'b0, 1'b0, 0, 0);   // single stop
        run_trial(3, 2'd2, 2'd2, 1'b0, 1'b0, 0, 0);   // already there
        run_trial(4, 2'd0, 2'd2, 1'b1, 1'b0, 0, 0);   // no convergence
        run_trial(5, 2'd0, 2'd3, 1'b0, 1'b1, 9, 1);   // estop in WAIT
        run_trial(6, 2'd2, 2'd1, 1'b0, 1'b1, 0, 1);   // estop with request in IDLE
        run_trial(7, 2'd1, 2'd3, 1'b0, 1'b1, 2, G+3); // long estop re-enters stop

        // Reset during the first up-strobe
        fan_ld_val = 2'd0; fan_ld = 1'b1; fan_stuck = 1'b0;
        @(posedge clk); @(negedge clk);
        fan_ld = 1'b0; bus.req_valid = 1'b1; bus.req_target = 2'd3;
        @(posedge clk); @(negedge clk);
        bus.req_valid = 1'b0;
        check("rst_check", obs(), 6'b0);
        @(posedge clk); @(negedge clk);
        check("rst_issue", obs(), V_UP);
        reset = 1'b1;
        @(posedge clk); @(negedge clk);
        check("rst_cut", obs(), V_RDY);
        reset = 1'b0;
        run_trial(8, 2'd0, 2'd3, 1'b0, 1'b0, 0, 0);

        for (int n = 0; n < 30; n++) begin
            run_trial(100 + n, 2'($urandom), 2'($urandom), ($urandom_range(3, 0) == 0),
                      ($urandom_range(2, 0) == 0), -1, int'($urandom_range(G + 3, 1)));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
